// File: rtl/sseg_capture.sv
// sseg_capture: receive-side monitor for a multiplexed 7-segment display.
//
// Samples the anode / segment / decimal-point lines driven to the panel,
// waits for a scan position to settle, decodes the segment pattern back to a
// hex nibble and keeps an 8-digit shadow of what the panel is showing.
//
// Optional feature: define SSEG_SCAN_RATE_EN to add the scan_period output,
// which reports the number of clocks between successive digit-0 captures.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   an[7:0]      anode lines, active-low, bit i selects digit i
//   sseg[6:0]    segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   clr          synchronous clear of digit_valid and err
//   hex_out      captured digits, nibble i = digit i
//   dp_out       captured decimal points, active-high
//   digit_valid  bit i set once digit i has been captured
//   update       one-cycle pulse when a digit register is written
//   update_idx   digit index of the current update / pattern_err pulse
//   pattern_err  one-cycle pulse: stable pattern does not decode
//   err          sticky error flag
//   scan_period  clocks between digit-0 captures (SSEG_SCAN_RATE_EN only)
module sseg_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SCAN_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        an,
  input  logic [6:0]        sseg,
  input  logic              dp,
  input  logic              clr,
  output logic [31:0]       hex_out,
  output logic [7:0]        dp_out,
  output logic [7:0]        digit_valid,
  output logic              update,
  output logic [2:0]        update_idx,
  output logic              pattern_err,
  output logic              err
`ifdef SSEG_SCAN_RATE_EN
  ,
  output logic [SCAN_W-1:0] scan_period
`endif
);

  localparam logic [7:0] StableLim = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

  // Sample bundle {an, sseg, dp}; the idle level of every line is all-ones.
  logic [15:0] sync1_q, sync2_q, s_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      s_q     <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {an, sseg, dp};
      sync2_q <= sync1_q;
      s_q     <= sync2_q;
      prev_q  <= s_q;
    end
  end

  logic [7:0] s_an;
  logic [6:0] s_seg;
  logic       s_dp;
  assign s_an  = s_q[15:8];
  assign s_seg = s_q[7:1];
  assign s_dp  = s_q[0];

  // Returns {valid, value}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  logic       legal, changed, dec_ok;
  logic [3:0] dec_val;
  logic [2:0] dig;

  assign legal            = $onehot(~s_an);
  assign changed          = (s_q != prev_q);
  assign {dec_ok, dec_val} = decode(s_seg);

  always_comb begin
    dig = '0;
    for (int i = 0; i < 8; i++) begin
      if (!s_an[i]) dig = 3'(i);
    end
  end

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  dpo_q, dpo_d;
  logic [7:0]  dv_q, dv_d;
  logic        upd_q, upd_d;
  logic [2:0]  idx_q, idx_d;
  logic        perr_q, perr_d;
  logic        err_q, err_d;
  logic        go_count;
  logic [7:0]  cnt_n;
`ifdef SSEG_SCAN_RATE_EN
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d, scan_per_q, scan_per_d, scan_inc;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    dpo_d    = dpo_q;
    dv_d     = clr ? 8'h00 : dv_q;
    err_d    = clr ? 1'b0 : err_q;
    upd_d    = 1'b0;
    perr_d   = 1'b0;
    idx_d    = idx_q;
    go_count = 1'b0;
    cnt_n    = 8'd1;

    unique case (state_q)
      StIdle: begin
        if (legal) go_count = 1'b1;
      end
      StCount: begin
        if (changed) begin
          if (legal) go_count = 1'b1;
          else state_d = StIdle;
        end else begin
          go_count = 1'b1;
          cnt_n    = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (changed) begin
          if (legal) go_count = 1'b1;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_count) begin
      state_d = StCount;
      cnt_d   = cnt_n;
      // Capture when the run of identical samples reaches the limit; set beats clr.
      if (cnt_n == StableLim) begin
        state_d = StHold;
        idx_d   = dig;
        if (dec_ok) begin
          hex_d[{dig, 2'b00} +: 4] = dec_val;
          dpo_d[dig]               = ~s_dp;
          dv_d[dig]                = 1'b1;
          upd_d                    = 1'b1;
        end else begin
          perr_d = 1'b1;
          err_d  = 1'b1;
        end
      end
    end

`ifdef SSEG_SCAN_RATE_EN
    scan_inc   = (&scan_cnt_q) ? scan_cnt_q : scan_cnt_q + SCAN_W'(1);
    scan_cnt_d = scan_inc;
    scan_per_d = scan_per_q;
    if (upd_d && (dig == 3'd0)) begin
      scan_cnt_d = '0;
      scan_per_d = scan_inc;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hex_q      <= '0;
      dpo_q      <= '0;
      dv_q       <= '0;
      upd_q      <= 1'b0;
      idx_q      <= '0;
      perr_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SSEG_SCAN_RATE_EN
      scan_cnt_q <= '0;
      scan_per_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      dpo_q      <= dpo_d;
      dv_q       <= dv_d;
      upd_q      <= upd_d;
      idx_q      <= idx_d;
      perr_q     <= perr_d;
      err_q      <= err_d;
`ifdef SSEG_SCAN_RATE_EN
      scan_cnt_q <= scan_cnt_d;
      scan_per_q <= scan_per_d;
`endif
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dpo_q;
  assign digit_valid = dv_q;
  assign update      = upd_q;
  assign update_idx  = idx_q;
  assign pattern_err = perr_q;
  assign err         = err_q;
`ifdef SSEG_SCAN_RATE_EN
  assign scan_period = scan_per_q;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
module tb_sseg_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  sseg = 7'h7F;
  logic        dp = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  digit_valid;
  logic        update;
  logic [2:0]  update_idx;
  logic        pattern_err;
  logic        err;
`ifdef SSEG_SCAN_RATE_EN
  logic [15:0] scan_period;
`endif

  sseg_capture #(.STABLE_CYCLES(4), .SCAN_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp),
    .clr         (clr),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .update      (update),
    .update_idx  (update_idx),
    .pattern_err (pattern_err),
    .err         (err)
`ifdef SSEG_SCAN_RATE_EN
    ,
    .scan_period (scan_period)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [2:0] idx;
    logic [3:0] val;
    logic       dpo;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_upd    = 0;
  int   n_perr   = 0;
  int   last_upd_cyc = -1;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every update / pattern_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (update || pattern_err)) begin
      if (update) begin
        n_upd++;
        last_upd_cyc = cyc;
      end
      if (pattern_err) n_perr++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: update=%0b pattern_err=%0b idx=%0d, none expected",
                 update, pattern_err, update_idx);
      end else begin
        e = q.pop_front();
        if (update !== !e.is_err || pattern_err !== e.is_err || update_idx !== e.idx) begin
          n_fail++;
          $display("FAIL pulse_kind: got upd=%0b perr=%0b idx=%0d, want err=%0b idx=%0d",
                   update, pattern_err, update_idx, e.is_err, e.idx);
        end
        if (!e.is_err) begin
          n_checks++;
          if ({hex_out[e.idx*4 +: 4], dp_out[e.idx]} !== {e.val, e.dpo}) begin
            n_fail++;
            $display("FAIL capture_data: digit %0d got val=%h dp=%b, want val=%h dp=%b",
                     e.idx, hex_out[e.idx*4 +: 4], dp_out[e.idx], e.val, e.dpo);
          end
        end
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d);
    an   = a;
    sseg = s;
    dp   = d;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clks(3);
    n_checks++;
    if ({hex_out, dp_out, digit_valid, update, update_idx, pattern_err, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: hex=%h dp=%h dv=%h upd=%b idx=%0d perr=%b err=%b, want 0",
               hex_out, dp_out, digit_valid, update, update_idx, pattern_err, err);
    end
    reset = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_single();
    int c0, u0;
    u0 = n_upd;
    q.push_back('{is_err: 1'b0, idx: 3'd0, val: 4'h3, dpo: 1'b0});
    c0 = cyc;
    drive(8'hFE, 7'h30, 1'b1);
    wait_clks(10);
    n_checks++;
    if (n_upd - u0 != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d updates, want 1", n_upd - u0);
    end
    n_checks++;
    if (last_upd_cyc - c0 != 7) begin
      n_fail++;
      $display("FAIL single_latency: got %0d clocks, want 7", last_upd_cyc - c0);
    end
    n_checks++;
    if (hex_out[3:0] !== 4'h3 || dp_out[0] !== 1'b0 || digit_valid !== 8'h01) begin
      n_fail++;
      $display("FAIL single_state: hex0=%h dp0=%b dv=%h, want 3 0 01",
               hex_out[3:0], dp_out[0], digit_valid);
    end
  endtask

  task automatic test_scan();
    int u0;
    for (int pass = 0; pass < 2; pass++) begin
      u0 = n_upd;
      for (int d = 0; d < 8; d++) begin
        q.push_back('{is_err: 1'b0, idx: 3'(d), val: 4'(d), dpo: (d == 5)});
        drive(~(8'h01 << d), pat[d], (d == 5) ? 1'b0 : 1'b1);
        wait_clks(20);
      end
      n_checks++;
      if (n_upd - u0 != 8) begin
        n_fail++;
        $display("FAIL scan_pass_count: pass %0d got %0d updates, want 8", pass, n_upd - u0);
      end
    end
    n_checks++;
    if (hex_out !== 32'h76543210 || dp_out !== 8'h20 || digit_valid !== 8'hFF) begin
      n_fail++;
      $display("FAIL scan_state: hex=%h dp=%h dv=%h, want 76543210 20 FF",
               hex_out, dp_out, digit_valid);
    end
`ifdef SSEG_SCAN_RATE_EN
    n_checks++;
    if (scan_period !== 16'd160) begin
      n_fail++;
      $display("FAIL scan_period: got %0d, want 160", scan_period);
    end
`endif
  endtask

  task automatic test_decode();
    logic [6:0] bad [2] = '{7'h7F, 7'h7E};
    for (int v = 0; v < 16; v++) begin
      q.push_back('{is_err: 1'b0, idx: 3'd7, val: 4'(v), dpo: ~v[0]});
      drive(8'h7F, pat[v], v[0]);
      wait_clks(9);
    end
    for (int b = 0; b < 2; b++) begin
      q.push_back('{is_err: 1'b1, idx: 3'd7, val: 4'h0, dpo: 1'b0});
      drive(8'h7F, bad[b], 1'b1);
      wait_clks(9);
    end
    n_checks++;
    if (q.size() != 0 || hex_out[31:28] !== 4'hF || err !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_end: pending=%0d hex7=%h err=%b, want 0 F 1",
               q.size(), hex_out[31:28], err);
    end
  endtask

  task automatic test_pattern_err();
    logic [31:0] hex0;
    int p0;
    drive(8'hFF, 7'h7F, 1'b1);
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
    wait_clks(5);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_before: err=%b, want 0", err);
    end
    hex0 = hex_out;
    p0   = n_perr;
    q.push_back('{is_err: 1'b1, idx: 3'd2, val: 4'h0, dpo: 1'b0});
    drive(8'hFB, 7'h7F, 1'b1);
    wait_clks(12);
    n_checks++;
    if (err !== 1'b1 || n_perr - p0 != 1 || hex_out !== hex0) begin
      n_fail++;
      $display("FAIL pattern_err: err=%b pulses=%0d hex=%h, want 1 1 %h",
               err, n_perr - p0, hex_out, hex0);
    end
    clr = 1'b1;
    wait_clks(1);
    clr = 1'b0;
    n_checks++;
    if (err !== 1'b0 || digit_valid !== 8'h00 || hex_out !== hex0) begin
      n_fail++;
      $display("FAIL clr_after: err=%b dv=%h hex=%h, want 0 00 %h",
               err, digit_valid, hex_out, hex0);
    end
  endtask

  task automatic test_glitch();
    int u0, p0;
    drive(8'hFF, 7'h7F, 1'b1);
    wait_clks(5);
    u0 = n_upd;
    p0 = n_perr;
    for (int k = 0; k < 15; k++) begin
      drive(8'hFE, (k % 2 == 0) ? 7'h40 : 7'h79, 1'b1);
      wait_clks(2);
    end
    n_checks++;
    if (n_upd - u0 != 0) begin
      n_fail++;
      $display("FAIL glitch_updates: got %0d, want 0", n_upd - u0);
    end
    drive(8'hFC, 7'h40, 1'b1);
    wait_clks(20);
    n_checks++;
    if (n_upd - u0 != 0 || n_perr - p0 != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_anode: updates=%0d perr=%0d err=%b, want 0 0 0",
               n_upd - u0, n_perr - p0, err);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    drive(8'hFF, 7'h7F, 1'b1);
    wait_clks(5);
    drive(8'hFD, 7'h24, 1'b1);
    wait_clks(5);
    reset = 1'b1;
    wait_clks(2);
    n_checks++;
    if ({hex_out, dp_out, digit_valid, update, update_idx, pattern_err, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: hex=%h dp=%h dv=%h upd=%b err=%b, want 0",
               hex_out, dp_out, digit_valid, update, err);
    end
    q.push_back('{is_err: 1'b0, idx: 3'd1, val: 4'h2, dpo: 1'b0});
    c0 = cyc;
    reset = 1'b0;
    wait_clks(10);
    n_checks++;
    if (last_upd_cyc - c0 != 7) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got %0d clocks, want 7", last_upd_cyc - c0);
    end
    n_checks++;
    if (hex_out !== 32'h00000020 || digit_valid !== 8'h02 || q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_state: hex=%h dv=%h pending=%0d, want 00000020 02 0",
               hex_out, digit_valid, q.size());
    end
  endtask

  initial begin
    wait_clks(1);
    test_reset();
    test_single();
    test_scan();
    test_decode();
    test_pattern_err();
    test_glitch();
    test_reset_mid();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected pulses never seen, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Receive-side monitor for the multiplexed 7-segment display interface: anode select, active-low segments, decimal point.
- Samples the lines the display drivers produce and filters scan transitions.
- Decodes each stable segment pattern back to a 4-bit hex value and keeps an 8-digit shadow of what the panel shows.
- Used as a bench/loopback checker beside the display drivers and for on-board self-test.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is captured (range 1..255).
- SCAN_W, 16, width of the scan-period counter (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- an  input  8  anode lines, active-low; bit i selects digit i
- sseg  input  7  segments {g,f,e,d,c,b,a}, active-low
- dp  input  1  decimal point, active-low
- clr  input  1  synchronous clear of digit_valid and err
- hex_out  output  32  captured digits; nibble i = digit i
- dp_out  output  8  captured decimal points, active-high
- digit_valid  output  8  bit i set once digit i has been captured
- update  output  1  one-cycle pulse when a digit register is written
- update_idx  output  3  digit index for the current update or pattern_err pulse
- pattern_err  output  1  one-cycle pulse: stable pattern does not decode
- err  output  1  sticky error flag
- scan_period  output  SCAN_W  clocks between successive digit-0 captures (optional feature only)

Behaviour:
- Reset (async, active-high) clears all outputs to 0, the synchronizers (an to 8'hFF, sseg to 7'h7F, dp to 1), and the stability counter; FSM returns to IDLE.
- an, sseg and dp each pass through a 2-flop synchronizer. The FSM sees the 3rd-stage compare register, i.e. sample s.
- Sample s "changes" when {an,sseg,dp} differs from the previous sample.
- An anode vector is legal only if exactly one bit is 0. All-ones means blank; multiple zeros is illegal.
- FSM:
  - IDLE: wait for a legal anode. If s is legal, load cnt=1 and go to COUNT.
  - COUNT: if s changes, reload cnt=1 (go to IDLE if s is not legal). Otherwise increment cnt. On reaching STABLE_CYCLES, perform the capture and go to HOLD.
  - HOLD: stay while s is unchanged. On change, go to COUNT with cnt=1 if s is legal, else to IDLE.
  - Multiple-low anode vector: always go to IDLE, no error raised (ghosting during anode overlap).
- Capture for digit i = index of the low anode bit:
  - Valid pattern: write hex_out[4i+3:4i], write dp_out[i]=~dp, set digit_valid[i], pulse update for 1 cycle, update_idx=i.
  - Invalid pattern: registers unchanged, pulse pattern_err, update_idx=i, set err.
- Decode table (sseg hex -> value):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - Any other pattern, including blank 7F, is invalid.
- Latency: input edge to update pulse = 2 sync + STABLE_CYCLES + 1 clocks. With the default this is 7 clocks.
- Re-capture of an unchanged digit happens only after the inputs change and settle again. No duplicate pulses while in HOLD.
- clr clears digit_valid and err in that cycle. If a capture or error occurs in the same cycle, the set wins for that bit/flag. hex_out and dp_out are not cleared by clr.
- Reset mid-count abandons the capture; no partial write.

Optional Feature:
- Macro SSEG_SCAN_RATE_EN.
- When defined: a SCAN_W-bit free-running counter restarts at every digit-0 capture. Its previous value +1 is loaded into scan_period at that capture. The counter saturates at all-ones. scan_period resets to 0.
- When undefined: the scan_period port and the counter are absent.

Test Plan:
- Hold an=8'hFE, sseg=7'h30, dp=1 for 10 clocks -> one update pulse at clock 7, update_idx=0, hex_out[3:0]=3, dp_out[0]=0, digit_valid=8'h01.
- Scan 8 digits (an cycling FE..7F, 20 clocks each) with patterns for 0..7, dp low on digit 5 -> hex_out=32'h76543210, dp_out=8'h20, digit_valid=8'hFF, exactly 8 update pulses per pass.
- an=8'hFB, sseg=7'h7F (blank) held -> pattern_err pulse, update_idx=2, err=1, hex_out unchanged. Next cycle clr -> err=0.
- Glitch: sseg toggles every 2 clocks with STABLE_CYCLES=4 -> no update. an=8'hFC (two low) held -> no update, no error.
- Assert reset mid-COUNT, then release and hold inputs -> all outputs 0 after reset; capture occurs a full 7 clocks after release.
- SSEG_SCAN_RATE_EN defined, 8 digits x 20 clocks scan -> scan_period=160 after second digit-0 capture.
